// File: rtl/control_pipeline_if.sv
// Handshake bundle between the ID-stage control unit/datapath and control_pipeline.
// The master side drives decoded ID controls plus the EX branch outcome; the slave side returns per-stage controls.
interface control_pipeline_if #(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
);
  logic                 ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
  logic [ALUCTRL_W-1:0] ALUControlD;
  logic [REG_AW-1:0]    Rs1D, Rs2D, RdD;
  logic                 PCSrcE;

  logic                 RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ValidE;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic [REG_AW-1:0]    Rs1E, Rs2E, RdE;
  logic                 RegWriteM, MemWriteM, ResultSrcM, ValidM;
  logic [REG_AW-1:0]    RdM;
  logic                 RegWriteW, ResultSrcW, ValidW;
  logic [REG_AW-1:0]    RdW;
  logic                 StallF, StallD, FlushD;
  logic [1:0]           ForwardAE, ForwardBE;
  logic [CNT_W-1:0]     InstRet;

  modport master (
    output ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD,
           Rs1D, Rs2D, RdD, PCSrcE,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, Rs1E, Rs2E, RdE,
           ValidE, RegWriteM, MemWriteM, ResultSrcM, RdM, ValidM, RegWriteW, ResultSrcW, RdW,
           ValidW, StallF, StallD, FlushD, ForwardAE, ForwardBE, InstRet
  );

  modport slave (
    input  ValidD, RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD, ALUControlD,
           Rs1D, Rs2D, RdD, PCSrcE,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE, Rs1E, Rs2E, RdE,
           ValidE, RegWriteM, MemWriteM, ResultSrcM, RdM, ValidM, RegWriteW, ResultSrcW, RdW,
           ValidW, StallF, StallD, FlushD, ForwardAE, ForwardBE, InstRet
  );
endinterface

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use stall, bubble insertion,
// EX forwarding selects and a retired-instruction counter.
module control_pipeline #(
  parameter int REG_AW    = 5,
  parameter int ALUCTRL_W = 3,
  parameter int CNT_W     = 32
) (
  input  logic          clk,
  input  logic          rst,
  control_pipeline_if.slave bus
);
  typedef struct packed {
    logic                 reg_write;
    logic                 alu_src;
    logic                 mem_write;
    logic                 result_src;
    logic                 branch;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
  } ex_t;

  ex_t               ex_d, ex_q;
  logic [3:1]        vld_pipe;  // [1]=E, [2]=M, [3]=W
  logic              reg_write_m, mem_write_m, result_src_m;
  logic [REG_AW-1:0] rd_m;
  logic              reg_write_w, result_src_w;
  logic [REG_AW-1:0] rd_w;
  logic [CNT_W-1:0]  inst_ret;
  logic              lu, flush_e;

  assign lu = vld_pipe[1] & ex_q.result_src & (ex_q.rd != '0) &
              ((ex_q.rd == bus.Rs1D) | (ex_q.rd == bus.Rs2D)) & bus.ValidD;
  assign flush_e = lu | bus.PCSrcE;

  // A bubble and a reset leave ID/EX in the same all-zero state.
  always_comb begin
    ex_d = '0;
    if (bus.ValidD && !flush_e)
      ex_d = '{reg_write: bus.RegWriteD, alu_src: bus.ALUSrcD, mem_write: bus.MemWriteD,
               result_src: bus.ResultSrcD, branch: bus.BranchD, alu_ctrl: bus.ALUControlD,
               rs1: bus.Rs1D, rs2: bus.Rs2D, rd: bus.RdD};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q         <= '0;
      vld_pipe     <= '0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      rd_m         <= '0;
      reg_write_w  <= 1'b0;
      result_src_w <= 1'b0;
      rd_w         <= '0;
      inst_ret     <= '0;
    end else begin
      ex_q         <= ex_d;
      vld_pipe     <= {vld_pipe[2:1], bus.ValidD & ~flush_e};
      reg_write_m  <= ex_q.reg_write;
      mem_write_m  <= ex_q.mem_write;
      result_src_m <= ex_q.result_src;
      rd_m         <= ex_q.rd;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
      rd_w         <= rd_m;
      if (vld_pipe[3]) inst_ret <= inst_ret + CNT_W'(1);
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (vld_pipe[2] && reg_write_m && rd_m != '0 && rd_m == src) return 2'b10;
    if (vld_pipe[3] && reg_write_w && rd_w != '0 && rd_w == src) return 2'b01;
    return 2'b00;
  endfunction

  assign bus.ForwardAE = vld_pipe[1] ? fwd_sel(ex_q.rs1) : 2'b00;
  assign bus.ForwardBE = vld_pipe[1] ? fwd_sel(ex_q.rs2) : 2'b00;

  assign bus.StallF      = lu;
  assign bus.StallD      = lu;
  assign bus.FlushD      = bus.PCSrcE;
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.ALUSrcE     = ex_q.alu_src;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.ResultSrcE  = ex_q.result_src;
  assign bus.BranchE     = ex_q.branch;
  assign bus.ALUControlE = ex_q.alu_ctrl;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.RdE         = ex_q.rd;
  assign bus.ValidE      = vld_pipe[1];
  assign bus.RegWriteM   = reg_write_m;
  assign bus.MemWriteM   = mem_write_m;
  assign bus.ResultSrcM  = result_src_m;
  assign bus.RdM         = rd_m;
  assign bus.ValidM      = vld_pipe[2];
  assign bus.RegWriteW   = reg_write_w;
  assign bus.ResultSrcW  = result_src_w;
  assign bus.RdW         = rd_w;
  assign bus.ValidW      = vld_pipe[3];
  assign bus.InstRet     = inst_ret;
endmodule
